// File: rtl/ising_phase_reader.sv
// Measures the phase of N oscillator lines against osc_ref over a clk window and reports one spin bit per line.
// Done follows an accepted start by window+3 cycles; start is ignored while busy; PHASE_READER_COUNTS_EN adds the counts port.
module ising_phase_reader #(
   parameter int N     = 3,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               osc_ref,
   input  logic [N-1:0]       osc_in,
   input  logic               start,
   input  logic               abort,
   input  logic [CNT_W-1:0]   window,
   output logic               busy,
   output logic               done,
   output logic [N-1:0]       spin
`ifdef PHASE_READER_COUNTS_EN
   ,
   output logic [N*CNT_W-1:0] counts
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_MEASURE, ST_DONE} state_t;

   state_t                     state, state_nxt;
   logic [1:0]                 rst_q;
   logic                       rst_ok;
   logic                       ref_s1, ref_s2;
   logic [N-1:0]               in_s1, in_s2;
   logic                       settle_q;
   logic [CNT_W-1:0]           win_q;
   logic [CNT_W-1:0]           cyc_q;
   logic [N-1:0][CNT_W-1:0]    cnt_q, cnt_nxt;
   logic [N-1:0]               spin_q;
   logic                       accept, finish;

   // Reset asserts immediately but release must propagate two edges before a start is honoured.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) rst_q <= 2'b00;
      else       rst_q <= {rst_q[0], 1'b1};
   end
   assign rst_ok = rst_q[1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ref_s1 <= 1'b0;
         ref_s2 <= 1'b0;
         in_s1  <= '0;
         in_s2  <= '0;
      end else begin
         ref_s1 <= osc_ref;
         ref_s2 <= ref_s1;
         in_s1  <= osc_in;
         in_s2  <= in_s1;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      finish    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && !abort && rst_ok) begin
               state_nxt = ST_SETTLE;
               accept    = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (abort)         state_nxt = ST_IDLE;
            else if (settle_q) state_nxt = ST_MEASURE;
         end
         ST_MEASURE: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (cyc_q == win_q - CNT_W'(1)) begin
               state_nxt = ST_DONE;
               finish    = 1'b1;
            end
         end
         ST_DONE:    state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_nxt = cnt_q;
      for (int i = 0; i < N; i++) begin
         cnt_nxt[i] = cnt_q[i] + CNT_W'(in_s2[i] == ref_s2);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= ST_IDLE;
         settle_q <= 1'b0;
         win_q    <= '0;
         cyc_q    <= '0;
      end else begin
         state    <= state_nxt;
         settle_q <= (state == ST_SETTLE) ? ~settle_q : 1'b0;
         cyc_q    <= (state == ST_MEASURE) ? cyc_q + CNT_W'(1) : '0;
         if (accept) win_q <= (window == '0) ? CNT_W'(1) : window;
      end
   end

   // Spin is resolved on the edge entering DONE, so it is already valid while done is high.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q  <= '0;
         spin_q <= '0;
      end else begin
         if (accept)                   cnt_q <= '0;
         else if (state == ST_MEASURE) cnt_q <= cnt_nxt;
         if (finish) begin
            for (int i = 0; i < N; i++) begin
               spin_q[i] <= ({cnt_nxt[i], 1'b0} > {1'b0, win_q});
            end
         end
      end
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);
   assign spin = spin_q;

`ifdef PHASE_READER_COUNTS_EN
   assign counts = cnt_q;
`endif

endmodule

// File: tb/tb_ising_phase_reader.sv
// Directed bench for ising_phase_reader: latency, tie rule, abort, ignored start, reset behaviour.
module tb_ising_phase_reader;

   localparam int N     = 3;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rstn;
   logic             start, abort;
   logic [CNT_W-1:0] window;
   logic             busy, done;
   logic [N-1:0]     spin;
   logic             free, gen, dir_ref;
   logic [N-1:0]     dir_in;
   logic             osc_ref;
   logic [N-1:0]     osc_in;
`ifdef PHASE_READER_COUNTS_EN
   logic [N*CNT_W-1:0] counts;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int e;
   int dones;

   always #5 clk = ~clk;
   initial gen = 1'b0;
   always #100 gen = ~gen;

   assign osc_ref = free ? gen : dir_ref;
   assign osc_in  = free ? {gen, ~gen, gen} : dir_in;

   ising_phase_reader #(.N(N), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .osc_ref (osc_ref),
      .osc_in  (osc_in),
      .start   (start),
      .abort   (abort),
      .window  (window),
      .busy    (busy),
      .done    (done),
      .spin    (spin)
`ifdef PHASE_READER_COUNTS_EN
      ,
      .counts  (counts)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Leaves the bench 1ns after the edge that sampled start (edge 0).
   task automatic pulse_start(input logic [CNT_W-1:0] w);
      @(negedge clk);
      window = w;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
   endtask

   task automatic wait_done(input int maxe, output int edge_no);
      int i;
      i       = 0;
      edge_no = -1;
      while (edge_no < 0 && i < maxe) begin
         i++;
         @(posedge clk);
         #1;
         if (done === 1'b1) edge_no = i;
      end
   endtask

   initial begin
      rstn = 1'b0; start = 1'b0; abort = 1'b0; window = '0;
      free = 1'b0; dir_ref = 1'b0; dir_in = '0;
      #12;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_spin", spin, 0);
      @(negedge clk); rstn = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Free-running 20-cycle oscillators, line 1 anti-phase.
      free = 1'b1;
      pulse_start(100);
      chk("t1_busy", busy, 1);
      wait_done(150, e);
      chk("t1_done_edge", e, 102);
      chk("t1_spin", spin, 3'b101);
`ifdef PHASE_READER_COUNTS_EN
      chk("t1_counts", counts, {16'd100, 16'd0, 16'd100});
`endif
      @(posedge clk); #1;
      chk("t1_busy_drop", busy, 0);
      chk("t1_done_pulse", done, 0);
      chk("t1_spin_hold", spin, 3'b101);

      // Abort at edge 20 of a 50-cycle window; restart at edge 22.
      free = 1'b0; dir_ref = 1'b0; dir_in = 3'b000;
      pulse_start(50);
      repeat (19) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_spin", spin, 3'b101);
      @(posedge clk); #1;
      chk("abort_idle_done", done, 0);
      start = 1'b1; window = 2;
      @(posedge clk); #1 start = 1'b0;
      chk("restart_busy", busy, 1);
      wait_done(10, e);
      chk("restart_done_edge", e, 4);
      chk("restart_spin", spin, 3'b111);

      // Start together with abort in IDLE is ignored.
      @(posedge clk); #1;
      start = 1'b1; abort = 1'b1; window = 4;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      chk("start_abort_busy", busy, 0);

      // Second start while busy with a different window is ignored.
      pulse_start(50);
      repeat (9) @(posedge clk);
      #1 start = 1'b1; window = 5;
      @(posedge clk); #1 start = 1'b0;
      chk("busy_start_busy", busy, 1);
      wait_done(60, e);
      chk("busy_start_done_edge", e, 42);

      // Tie: 5 of 10 agreements on line 0; start in the IDLE cycle after done.
      @(posedge clk); #1;
      chk("back2back_idle", busy, 0);
      dir_in = 3'b000;
      pulse_start(10);
      chk("tie5_busy", busy, 1);
      repeat (5) @(posedge clk);
      #1 dir_in[0] = 1'b1;
      wait_done(20, e);
      chk("tie5_done_edge", e, 7);
      chk("tie5_spin", spin, 3'b110);
`ifdef PHASE_READER_COUNTS_EN
      chk("tie5_counts", counts, {16'd10, 16'd10, 16'd5});
`endif

      // Window 0 is treated as 1.
      @(posedge clk); #1;
      dir_ref = 1'b1; dir_in = 3'b111;
      pulse_start(0);
      wait_done(10, e);
      chk("win0_done_edge", e, 3);
      chk("win0_spin", spin, 3'b111);

      // 6 of 10 agreements on line 0 is a majority; line 1 never agrees.
      @(posedge clk); #1;
      dir_ref = 1'b0; dir_in = 3'b010;
      pulse_start(10);
      repeat (6) @(posedge clk);
      #1 dir_in[0] = 1'b1;
      wait_done(20, e);
      chk("maj6_done_edge", e, 6);
      chk("maj6_spin", spin, 3'b101);
`ifdef PHASE_READER_COUNTS_EN
      chk("maj6_counts", counts, {16'd10, 16'd0, 16'd6});
`endif

      // Reset during a measurement.
      @(posedge clk); #1;
      pulse_start(50);
      repeat (29) @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("rst_mid_spin", spin, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_done", done, 0);
      @(negedge clk);
      rstn = 1'b1; start = 1'b1; window = 1;
      @(posedge clk); #1 start = 1'b0;
      chk("rst_sync_start_ignored", busy, 0);
      dones = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) dones++;
      end
      chk("rst_no_done", dones, 0);

      dir_ref = 1'b0; dir_in = 3'b100;
      pulse_start(3);
      wait_done(10, e);
      chk("post_rst_done_edge", e, 5);
      chk("post_rst_spin", spin, 3'b011);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ising_phase_reader.md
ISING_PHASE_READER -- requirements
Module: ising_phase_reader

Interface
REQ-001 Parameter N, default 3: number of oscillator lines read.
REQ-002 Parameter CNT_W, default 16: width of window and agreement counters.
REQ-003 clk  input  1  single block clock; all state on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 osc_ref  input  1  reference oscillator line, asynchronous to clk; defines spin +1 phase.
REQ-006 osc_in  input  N  oscillator lines under measurement, asynchronous to clk.
REQ-007 start  input  1  one-cycle request to begin a measurement.
REQ-008 abort  input  1  synchronous cancel of an in-progress measurement.
REQ-009 window  input  CNT_W  measurement length in clk cycles, latched on accepted start.
REQ-010 busy  output  1  high from accepted start until return to IDLE.
REQ-011 done  output  1  one-cycle pulse when spin is updated.
REQ-012 spin  output  N  per-line result: 1 = in phase with osc_ref, 0 = anti-phase or tie.

Function
REQ-013 Each osc_in bit and osc_ref SHALL pass through a 2-flop synchronizer before any use.
REQ-014 FSM states SHALL be IDLE, SETTLE, MEASURE, DONE.
REQ-015 IDLE: start=1 SHALL latch window (0 replaced by 1), clear all agreement counters, assert busy, go to SETTLE.
REQ-016 SETTLE SHALL last exactly 2 cycles (synchronizer flush), then go to MEASURE.
REQ-017 MEASURE: each cycle, counter i SHALL increment when synced osc_in[i] equals synced osc_ref; after latched-window cycles go to DONE.
REQ-018 Counters cannot overflow (count <= window <= 2^CNT_W-1); no saturation logic required.
REQ-019 DONE (one cycle): spin[i] SHALL be 1 iff 2*count[i] > window (CNT_W+1-bit compare), else 0; done=1; next state IDLE.
REQ-020 Latency: start accepted at edge k SHALL give done high in cycle k+3+W, W = latched window.
REQ-021 spin SHALL hold its value between done pulses; only DONE updates it.
REQ-022 busy SHALL drop in the cycle after done; start in that IDLE cycle is accepted.
REQ-023 start while busy SHALL be ignored; window changes while busy SHALL have no effect.
REQ-024 abort in SETTLE or MEASURE SHALL return to IDLE next edge, no done, spin unchanged; abort has priority over window completion.
REQ-025 abort and start together in IDLE: start SHALL be ignored.

Reset
REQ-026 rstn low SHALL immediately force state IDLE, busy=0, done=0, spin=0, counters and synchronizers 0.
REQ-027 Reset mid-measurement SHALL discard it; no done pulse after rstn release.
REQ-028 Deassertion SHALL be synchronized inside the block before FSM leaves IDLE.

Configuration
REQ-029 Macro PHASE_READER_COUNTS_EN: when defined, SHALL add output counts (N*CNT_W), count[i] at bits [i*CNT_W +: CNT_W], valid from done and held until next accepted start.
REQ-030 Without PHASE_READER_COUNTS_EN, port counts SHALL not exist and counters SHALL not be visible; all other behaviour identical.

Verification
REQ-031 N=3, window=100, osc_in[0]=osc_ref, osc_in[1]=~osc_ref, osc_in[2]=osc_ref, period 20 clk -> done at k+103, spin=3'b101.
REQ-032 window=0, osc_in tied equal to osc_ref -> treated as 1, done at k+4, spin=3'b111.
REQ-033 window=10, osc_in[0] agrees exactly 5 cycles -> tie, spin[0]=0; with COUNTS_EN counts[CNT_W-1:0]=5.
REQ-034 start window=50, abort at cycle k+20 -> busy low at k+21, no done, spin keeps prior 3'b101; start at k+22 accepted.
REQ-035 start window=50, second start at k+10 with window=5 -> ignored; done at k+53.
REQ-036 rstn low at k+30 of window=50 measurement -> spin=0, busy=0 immediately; no done within 100 cycles after release.
